// File: rtl/rom_download_router.sv
`default_nettype none
// ============================================================================
//  Module   : rom_download_router
//  Brief    : Splits 16-bit HPS download words into byte writes, routes each
//             byte to a ROM/PROM write port by address, throttles the HPS and
//             holds the core in reset during and after a download.
//             Optional feature macro: ROM_ROUTER_CHECKSUM_EN (byte checksum).
//  Revision : 1.0 - initial release
// ============================================================================
module rom_download_router #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        cpu_rom_we,
    output logic        gfx_rom_we,
    output logic        pal_prom_we,
    output logic        lut_prom_we,
    output logic        core_reset_n,
    output logic        dl_done,
    output logic        overflow,
    output logic [7:0]  checksum
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_wr_lo = 2'd1;
    localparam logic [1:0] c_st_wr_hi = 2'd2;

    localparam logic [7:0] c_hold_cycles = 8'(HOLD_CYCLES);

    // One-hot select {lut, pal, gfx, cpu}; all-zero means the byte is out of map
    function automatic logic [3:0] f_decode(input logic [15:0] a, input logic hi);
        f_decode = 4'b0000;
        if (!hi) begin
            if (a < 16'h8000)      f_decode = 4'b0001;
            else if (a < 16'hA000) f_decode = 4'b0010;
            else if (a < 16'hA020) f_decode = 4'b0100;
            else if (a < 16'hA120) f_decode = 4'b1000;
        end
    endfunction

    logic [1:0]  r_state;
    logic [14:0] r_addr;
    logic [15:0] r_dout;
    logic        r_hi;
    logic        r_dl_prev;
    logic        r_pend;
    logic [7:0]  r_cnt;
    logic        r_wait;
    logic [15:0] r_rom_addr;
    logic [7:0]  r_rom_data;
    logic [3:0]  r_we;
    logic        r_core_rst_n;
    logic        r_dl_done;
    logic        r_overflow;

    logic [1:0]  w_state_nxt;
    logic        w_latch;
    logic        w_byte_vld;
    logic [15:0] w_byte_addr;
    logic [7:0]  w_byte_data;
    logic        w_byte_hi;
    logic [3:0]  w_we_nxt;
    logic        w_oob;
    logic        w_rise;
    logic        w_fall;
    logic        w_force;
    logic        w_done_evt;
    logic        w_pend_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_unused_addr0;

    assign w_unused_addr0 = ioctl_addr[0];

    // Next state and the byte to present in the coming cycle
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_byte_vld  = 1'b0;
        w_byte_addr = 16'h0000;
        w_byte_data = 8'h00;
        w_byte_hi   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (ioctl_download && ioctl_wr) begin
                    w_state_nxt = c_st_wr_lo;
                    w_latch     = 1'b1;
                    w_byte_vld  = 1'b1;
                    w_byte_addr = {ioctl_addr[15:1], 1'b0};
                    w_byte_data = ioctl_dout[7:0];
                    w_byte_hi   = |ioctl_addr[26:16];
                end
            end
            c_st_wr_lo: begin
                w_state_nxt = c_st_wr_hi;
                w_byte_vld  = 1'b1;
                w_byte_addr = {r_addr, 1'b1};
                w_byte_data = r_dout[15:8];
                w_byte_hi   = r_hi;
            end
            c_st_wr_hi: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign w_we_nxt = w_byte_vld ? f_decode(w_byte_addr, w_byte_hi) : 4'b0000;
    assign w_oob    = w_byte_vld && (w_we_nxt == 4'b0000);

    assign w_rise = ioctl_download && !r_dl_prev;
    assign w_fall = !ioctl_download && r_dl_prev;

    // A fall seen mid-word is remembered until the FSM lands back in idle
    assign w_done_evt = (w_fall || r_pend) && (w_state_nxt == c_st_idle);
    assign w_pend_nxt = (w_fall || r_pend) && (w_state_nxt != c_st_idle);

    assign w_force   = ioctl_download || (r_state != c_st_idle);
    assign w_cnt_nxt = w_force ? c_hold_cycles :
                       (r_cnt != 8'd0) ? (r_cnt - 8'd1) : 8'd0;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_st_idle;
            r_addr       <= '0;
            r_dout       <= '0;
            r_hi         <= 1'b0;
            r_dl_prev    <= 1'b0;
            r_pend       <= 1'b0;
            r_cnt        <= c_hold_cycles;
            r_wait       <= 1'b0;
            r_rom_addr   <= '0;
            r_rom_data   <= '0;
            r_we         <= '0;
            r_core_rst_n <= 1'b0;
            r_dl_done    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_addr <= ioctl_addr[15:1];
                r_dout <= ioctl_dout;
                r_hi   <= |ioctl_addr[26:16];
            end
            r_wait <= (w_state_nxt != c_st_idle);
            if (w_byte_vld) begin
                r_rom_addr <= w_byte_addr;
                r_rom_data <= w_byte_data;
            end
            r_we         <= w_we_nxt;
            r_dl_prev    <= ioctl_download;
            r_pend       <= w_pend_nxt;
            r_dl_done    <= w_done_evt;
            r_cnt        <= w_cnt_nxt;
            // Registered against the next count so the rise lands HOLD_CYCLES after release
            r_core_rst_n <= !w_force && (w_cnt_nxt == 8'd0);
            if (w_rise)
                r_overflow <= 1'b0;
            else if (w_oob)
                r_overflow <= 1'b1;
        end
    end

`ifdef ROM_ROUTER_CHECKSUM_EN
    logic [7:0] r_checksum;

    // Accumulates the byte presented with a write enable, one cycle after it
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            r_checksum <= 8'h00;
        else if (w_rise)
            r_checksum <= 8'h00;
        else if (|r_we)
            r_checksum <= r_checksum + r_rom_data;
    end

    assign checksum = r_checksum;
`else
    assign checksum = 8'h00;
`endif

    assign ioctl_wait   = r_wait;
    assign rom_addr     = r_rom_addr;
    assign rom_data     = r_rom_data;
    assign cpu_rom_we   = r_we[0];
    assign gfx_rom_we   = r_we[1];
    assign pal_prom_we  = r_we[2];
    assign lut_prom_we  = r_we[3];
    assign core_reset_n = r_core_rst_n;
    assign dl_done      = r_dl_done;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rom_download_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_download_router
//  Brief    : Scoreboard bench for rom_download_router; expected byte writes
//             are queued at strobe time and popped when a write enable shows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_download_router;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        cpu_rom_we;
    logic        gfx_rom_we;
    logic        pal_prom_we;
    logic        lut_prom_we;
    logic        core_reset_n;
    logic        dl_done;
    logic        overflow;
    logic [7:0]  checksum;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0]  we;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic [3:0] w_we_vec;

    assign w_we_vec = {lut_prom_we, pal_prom_we, gfx_rom_we, cpu_rom_we};

    always #5 clk_sys = ~clk_sys;

    rom_download_router #(.HOLD_CYCLES(16)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .cpu_rom_we     (cpu_rom_we),
        .gfx_rom_we     (gfx_rom_we),
        .pal_prom_we    (pal_prom_we),
        .lut_prom_we    (lut_prom_we),
        .core_reset_n   (core_reset_n),
        .dl_done        (dl_done),
        .overflow       (overflow),
        .checksum       (checksum)
    );

    // Memory map from the port list: cpu / gfx / pal / lut, anything else unmapped
    function automatic logic [3:0] model_we(input logic [26:0] ba);
        if (ba[26:16] != 11'd0)          return 4'b0000;
        if (ba[15:0] <= 16'h7FFF)        return 4'b0001;
        if (ba[15:0] <= 16'h9FFF)        return 4'b0010;
        if (ba[15:0] <= 16'hA01F)        return 4'b0100;
        if (ba[15:0] <= 16'hA11F)        return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic push_word(input logic [26:0] a, input logic [15:0] d);
        logic [26:0] ba;
        exp_t        e;
        ba = {a[26:1], 1'b0};
        e.we = model_we(ba); e.addr = ba[15:0]; e.data = d[7:0];
        if (e.we != 4'b0000) q.push_back(e);
        ba[0] = 1'b1;
        e.we = model_we(ba); e.addr = ba[15:0]; e.data = d[15:8];
        if (e.we != 4'b0000) q.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the strobe edge
    task automatic strobe(input logic [26:0] a, input logic [15:0] d);
        int guard;
        guard = 0;
        while (ioctl_wait === 1'b1 && guard < 10) begin
            @(posedge clk_sys); #1;
            guard++;
        end
        if (guard >= 10) begin
            n_cmp++; n_err++;
            $display("FAIL wait_timeout: ioctl_wait=%b after %0d cycles, required 0", ioctl_wait, guard);
        end
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr   = 1'b0;
    endtask

    task automatic send_word(input logic [26:0] a, input logic [15:0] d);
        push_word(a, d);
        strobe(a, d);
        repeat (2) begin @(posedge clk_sys); #1; end
    endtask

    task automatic restart_download();
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        repeat (2) begin @(posedge clk_sys); #1; end
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
    endtask

    // Scoreboard monitor: every write enable must match the head of the queue
    always @(negedge clk_sys) begin
        if (reset_n === 1'b1 && w_we_vec !== 4'b0000) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: we=%b addr=%h data=%h, required no write", w_we_vec, rom_addr, rom_data);
            end else begin
                mon_e = q.pop_front();
                if ({w_we_vec, rom_addr, rom_data} !== mon_e || ioctl_wait !== 1'b1) begin
                    n_err++;
                    $display("FAIL byte_write: we=%b addr=%h data=%h wait=%b, required we=%b addr=%h data=%h wait=1",
                             w_we_vec, rom_addr, rom_data, ioctl_wait, mon_e.we, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic test_reset();
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        n_cmp++;
        if ({ioctl_wait, w_we_vec, rom_addr, rom_data, core_reset_n, dl_done, overflow, checksum} !== '0) begin
            n_err++;
            $display("FAIL reset_values: wait=%b we=%b addr=%h data=%h crst=%b done=%b ovf=%b cks=%h, required all 0",
                     ioctl_wait, w_we_vec, rom_addr, rom_data, core_reset_n, dl_done, overflow, checksum);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk_sys);
            n_cmp++;
            if (core_reset_n !== (i == 16)) begin
                n_err++;
                $display("FAIL reset_release_hold: edge %0d core_reset_n=%b, required %b", i, core_reset_n, (i == 16));
            end
        end
    endtask

    task automatic test_single_word();
        @(posedge clk_sys); #1;
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        push_word(27'h0000000, 16'hA55A);
        strobe(27'h0000000, 16'hA55A);
        n_cmp++;
        if ({ioctl_wait, cpu_rom_we, rom_addr, rom_data} !== {1'b1, 1'b1, 16'h0000, 8'h5A}) begin
            n_err++;
            $display("FAIL single_lo: wait=%b cpu_we=%b addr=%h data=%h, required 1 1 0000 5a", ioctl_wait, cpu_rom_we, rom_addr, rom_data);
        end
        @(posedge clk_sys); #1;
        n_cmp++;
        if ({ioctl_wait, cpu_rom_we, rom_addr, rom_data} !== {1'b1, 1'b1, 16'h0001, 8'hA5}) begin
            n_err++;
            $display("FAIL single_hi: wait=%b cpu_we=%b addr=%h data=%h, required 1 1 0001 a5", ioctl_wait, cpu_rom_we, rom_addr, rom_data);
        end
        @(posedge clk_sys); #1;
        n_cmp++;
        if ({ioctl_wait, w_we_vec, core_reset_n} !== {1'b0, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL single_end: wait=%b we=%b crst=%b, required 0 0000 0", ioctl_wait, w_we_vec, core_reset_n);
        end
    endtask

    task automatic test_region();
        logic [26:0] addrs [6];
        addrs = '{27'h0007FFE, 27'h0008000, 27'h0009FFE, 27'h000A01E, 27'h000A020, 27'h000A11E};
        for (int i = 0; i < 6; i++) begin
            send_word(addrs[i], 16'h1100 + 16'(i * 16'h0203));
            n_cmp++;
            if (overflow !== 1'b0 || q.size() != 0) begin
                n_err++;
                $display("FAIL region_map %h: overflow=%b pending=%0d, required 0 0", addrs[i], overflow, q.size());
            end
        end
        send_word(27'h000A120, 16'hDEAD);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL region_a120: overflow=%b, required 1", overflow);
        end
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        n_cmp++;
        if (dl_done !== 1'b0) begin
            n_err++;
            $display("FAIL dl_done_early: dl_done=%b, required 0", dl_done);
        end
        @(negedge clk_sys);
        n_cmp++;
        if (dl_done !== 1'b1) begin
            n_err++;
            $display("FAIL dl_done_idle: dl_done=%b, required 1", dl_done);
        end
        @(negedge clk_sys);
        n_cmp++;
        if (dl_done !== 1'b0) begin
            n_err++;
            $display("FAIL dl_done_width: dl_done=%b, required 0", dl_done);
        end
        @(posedge clk_sys); #1;
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_clear: overflow=%b, required 0", overflow);
        end
        send_word(27'h0010000, 16'hBEEF);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_err++;
            $display("FAIL region_high_addr: overflow=%b, required 1", overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [26:0] addrs [4];
        addrs = '{27'h0000100, 27'h0008100, 27'h000A000, 27'h000A100};
        for (int i = 0; i < 4; i++) begin
            send_word(addrs[i], 16'h5000 + 16'(i * 16'h1111));
            n_cmp++;
            if (ioctl_wait !== 1'b0 || q.size() != 0) begin
                n_err++;
                $display("FAIL back_to_back %0d: wait=%b pending=%0d, required 0 0", i, ioctl_wait, q.size());
            end
        end
    endtask

    task automatic test_dl_end_mid_word();
        push_word(27'h0000200, 16'h9966);
        strobe(27'h0000200, 16'h9966);
        ioctl_download = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk_sys);
            if (k <= 3) begin
                n_cmp++;
                if (dl_done !== (k == 3)) begin
                    n_err++;
                    $display("FAIL dl_end_done: cycle N+%0d dl_done=%b, required %b", k, dl_done, (k == 3));
                end
            end
            if (k >= 3) begin
                n_cmp++;
                if (core_reset_n !== (k == 19)) begin
                    n_err++;
                    $display("FAIL dl_end_core_reset: cycle N+%0d core_reset_n=%b, required %b", k, core_reset_n, (k == 19));
                end
            end
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL dl_end_bytes: pending=%0d, required 0", q.size());
        end
        @(posedge clk_sys); #1;
    endtask

    task automatic test_checksum();
        logic [7:0] exp_sum;
        logic [7:0] lo;
        logic [7:0] hi;
        exp_sum = 8'h00;
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        send_word(27'h000A120, 16'h0000);
        restart_download();
        n_cmp++;
        if (checksum !== 8'h00 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL checksum_start: checksum=%h overflow=%b, required 00 0", checksum, overflow);
        end
        for (int k = 0; k < 128; k++) begin
            lo = 8'(2 * k + 1);
            hi = 8'(2 * k + 2);
            send_word(27'(2 * k), {hi, lo});
`ifdef ROM_ROUTER_CHECKSUM_EN
            exp_sum = exp_sum + lo + hi;
`endif
        end
        n_cmp++;
        if (checksum !== exp_sum) begin
            n_err++;
            $display("FAIL checksum_total: checksum=%h, required %h", checksum, exp_sum);
        end
        send_word(27'h000A200, 16'h7777);
        restart_download();
        n_cmp++;
        if (checksum !== 8'h00 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL checksum_restart: checksum=%h overflow=%b, required 00 0", checksum, overflow);
        end
    endtask

    task automatic test_reset_mid_word();
        exp_t e;
        e.we = 4'b0010; e.addr = 16'h8000; e.data = 8'h44;
        q.push_back(e);
        strobe(27'h0008000, 16'h3344);
        @(negedge clk_sys); #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({w_we_vec, ioctl_wait, rom_addr, rom_data, core_reset_n} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_word: we=%b wait=%b addr=%h data=%h crst=%b, required all 0",
                     w_we_vec, ioctl_wait, rom_addr, rom_data, core_reset_n);
        end
        @(posedge clk_sys); #1;
        n_cmp++;
        if (w_we_vec !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid_word_hold: we=%b, required 0000", w_we_vec);
        end
        reset_n = 1'b1;
        repeat (4) begin @(posedge clk_sys); #1; end
        send_word(27'h0000002, 16'h7788);
        n_cmp++;
        if (q.size() != 0 || ioctl_wait !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_word_recover: pending=%0d wait=%b, required 0 0", q.size(), ioctl_wait);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_region();
        test_back_to_back();
        test_dl_end_mid_word();
        test_checksum();
        test_reset_mid_word();
        repeat (3) @(posedge clk_sys);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/rom_download_router.md
# rom_download_router

Sits between the HPS download port and the MrJong core: takes the 16-bit `ioctl` word stream for `ioctl_index==0` and serialises each word into two byte writes. Each byte is routed to one of four on-chip ROM/PROM write ports by address. The block throttles the HPS with `ioctl_wait` and holds the core in reset while a download is in progress and for a fixed time after it.

## Interface
Parameters:
- `HOLD_CYCLES`, 16: `core_reset_n` low-time after the download ends, in `clk_sys` cycles (range 1–255).

Ports:
- `clk_sys` in 1: system clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: download active, already qualified to index 0.
- `ioctl_wr` in 1: one-cycle word strobe.
- `ioctl_addr` in 27: byte address of the word (always even).
- `ioctl_dout` in 16: word; `[7:0]` is byte at `addr`, `[15:8]` is byte at `addr+1`.
- `ioctl_wait` out 1: busy, HPS must not strobe.
- `rom_addr` out 16: byte address for the current write.
- `rom_data` out 8: byte for the current write.
- `cpu_rom_we` out 1: write enable, 0x0000–0x7FFF.
- `gfx_rom_we` out 1: write enable, 0x8000–0x9FFF.
- `pal_prom_we` out 1: write enable, 0xA000–0xA01F.
- `lut_prom_we` out 1: write enable, 0xA020–0xA11F.
- `core_reset_n` out 1: active-low reset to the core.
- `dl_done` out 1: one-cycle pulse when a download completes.
- `overflow` out 1: sticky; a byte fell outside every region.
- `checksum` out 8: byte sum of the current download.

## Operation
- FSM states `IDLE`, `WR_LO`, `WR_HI`.
- `IDLE`: if `ioctl_download & ioctl_wr`:
  - latch `ioctl_addr[15:1]`, `ioctl_dout` and `ioctl_addr[26:16]!=0` (high-address flag);
  - go to `WR_LO`.
- `WR_LO`: present the low byte at `{addr[15:1],1'b0}`, then go to `WR_HI`.
- `WR_HI`: present the high byte at `{addr[15:1],1'b1}`, then go to `IDLE`.
- `ioctl_wr` outside `IDLE`, or without `ioctl_download`, is ignored (protocol violation, no state change).
- `ioctl_addr[0]` is ignored.
- Each byte is decoded independently, so a word that straddles a region boundary splits correctly.
- At most one `*_we` is high at a time, and only in `WR_LO`/`WR_HI`.
- Out-of-map bytes (address ≥0xA120, or high-address flag set):
  - no `*_we`;
  - `overflow` set to 1.
- `overflow` and `checksum` clear on the rising edge of `ioctl_download`.
- Falling edge of `ioctl_download` while a word is in flight: the word completes, and `dl_done` pulses the cycle the FSM returns to `IDLE`.
- `core_reset_n` is 0 while any of these holds:
  - `reset_n` is 0;
  - `ioctl_download` is 1;
  - the FSM is not `IDLE`;
  - the hold counter is non-zero.
- Hold counter:
  - loads `HOLD_CYCLES` every cycle the first three conditions hold;
  - otherwise decrements to 0 and saturates.

## Timing
- Reset values:
  - outputs: `ioctl_wait`, every `*_we`, `rom_addr`, `rom_data`, `core_reset_n`, `dl_done`, `overflow`, `checksum` all 0;
  - internal: FSM in `IDLE`, hold counter = `HOLD_CYCLES`.
- All outputs are registered.
- Word write sequence, with strobe sampled at edge N:
  - cycle N+1: `ioctl_wait`=1, low-byte `we`;
  - cycle N+2: `ioctl_wait`=1, high-byte `we`;
  - cycle N+3: `ioctl_wait`=0.
- Minimum strobe spacing is 3 cycles.
- `rom_addr` and `rom_data` are valid in the same cycle as their `we`.
- `dl_done` timing:
  - if idle at the falling edge of `ioctl_download`, it pulses one cycle after that edge;
  - if a word is in flight, it pulses the cycle the FSM reaches `IDLE`.
- `core_reset_n` rises exactly `HOLD_CYCLES` cycles after its last forcing condition clears.
- `reset_n` asserted mid-word aborts the word immediately: partial byte lost, no `we`, all outputs return to reset values.

## Configuration
- `ROM_ROUTER_CHECKSUM_EN` defined:
  - `checksum` accumulates `checksum + byte` modulo 256 for every in-map byte written;
  - it updates in the cycle after the byte's `we`.
- Not defined: `checksum` is tied to 0 and the adder is not synthesised.

## Test plan
- **Reset release:** `reset_n` 0→1 with no download → `core_reset_n` rises after 16 cycles; all `we` stay 0.
- **Single word:** addr 0x0000, dout 0xA55A →
  - cycle N+1: `cpu_rom_we`, `rom_addr`=0x0000, `rom_data`=0x5A;
  - cycle N+2: `rom_addr`=0x0001, `rom_data`=0xA5;
  - `ioctl_wait` high for exactly 2 cycles.
- **Region decode:**
  - word at 0x7FFE → `cpu_rom_we`;
  - word at 0x8000 → `gfx_rom_we`;
  - word at 0xA01E → `pal_prom_we` ×2;
  - word at 0xA020 → `lut_prom_we`;
  - word at 0xA120 → no `we`, `overflow`=1;
  - word at 0x1_0000 → no `we`, `overflow`=1.
- **Download end mid-word:** drop `ioctl_download` the cycle after the strobe → both bytes written, `dl_done` pulses at N+3, `core_reset_n` rises at N+3+16.
- **Reset mid-word:** pull `reset_n` low in `WR_LO` → `we` is 0 next cycle; no `WR_HI` write occurs.
- **Checksum (macro on):** download bytes 0x01..0xFF then 0x00 → `checksum`=0x80; new download start → `checksum`=0 and `overflow`=0.
